// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Master-side request/grant/completion signals for two masters
//               plus the shared RAM data port, grouped for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  m0_req;
   logic                  m0_wEn;
   logic [ADDR_WIDTH-1:0] m0_address;
   logic [DATA_WIDTH-1:0] m0_write_data;
   logic                  m0_gnt;
   logic                  m0_valid;
   logic [DATA_WIDTH-1:0] m0_read_data;

   logic                  m1_req;
   logic                  m1_wEn;
   logic [ADDR_WIDTH-1:0] m1_address;
   logic [DATA_WIDTH-1:0] m1_write_data;
   logic                  m1_gnt;
   logic                  m1_valid;
   logic [DATA_WIDTH-1:0] m1_read_data;

   logic                  wEn;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [DATA_WIDTH-1:0] d_write_data;
   logic [DATA_WIDTH-1:0] d_read_data;

   modport slave (
      input  m0_req, m0_wEn, m0_address, m0_write_data,
      output m0_gnt, m0_valid, m0_read_data,
      input  m1_req, m1_wEn, m1_address, m1_write_data,
      output m1_gnt, m1_valid, m1_read_data,
      output wEn, d_address, d_write_data,
      input  d_read_data
   );

   modport master (
      output m0_req, m0_wEn, m0_address, m0_write_data,
      input  m0_gnt, m0_valid, m0_read_data,
      output m1_req, m1_wEn, m1_address, m1_write_data,
      input  m1_gnt, m1_valid, m1_read_data,
      input  wEn, d_address, d_write_data,
      output d_read_data
   );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin two-master arbiter for the single RAM data port;
//               one transaction per two cycles, registered gnt/valid/read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  wire logic           clock,
   input  wire logic           reset,
   ram_port_arbiter_if.slave   bus
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                r_state, w_state;
   logic                  r_prio, w_prio;
   logic                  r_id, w_id;
   logic                  r_wen, w_wen;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
   logic                  r_m0_gnt, w_m0_gnt, r_m1_gnt, w_m1_gnt;
   logic                  r_m0_valid, w_m0_valid, r_m1_valid, w_m1_valid;
   logic [DATA_WIDTH-1:0] r_m0_rdata, w_m0_rdata, r_m1_rdata, w_m1_rdata;
   logic                  w_sel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_prio     <= 1'b0;
         r_id       <= 1'b0;
         r_wen      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_m0_gnt   <= 1'b0;
         r_m1_gnt   <= 1'b0;
         r_m0_valid <= 1'b0;
         r_m1_valid <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         r_state    <= w_state;
         r_prio     <= w_prio;
         r_id       <= w_id;
         r_wen      <= w_wen;
         r_addr     <= w_addr;
         r_wdata    <= w_wdata;
         r_m0_gnt   <= w_m0_gnt;
         r_m1_gnt   <= w_m1_gnt;
         r_m0_valid <= w_m0_valid;
         r_m1_valid <= w_m1_valid;
         r_m0_rdata <= w_m0_rdata;
         r_m1_rdata <= w_m1_rdata;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_prio     = r_prio;
      w_id       = r_id;
      w_wen      = r_wen;
      w_addr     = r_addr;
      w_wdata    = r_wdata;
      w_m0_gnt   = 1'b0;
      w_m1_gnt   = 1'b0;
      w_m0_valid = 1'b0;
      w_m1_valid = 1'b0;
      w_m0_rdata = r_m0_rdata;
      w_m1_rdata = r_m1_rdata;
      w_sel      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               // On a tie the pointer picks; otherwise the lone requester wins.
               w_sel    = (bus.m0_req && bus.m1_req) ? r_prio : bus.m1_req;
               w_id     = w_sel;
               w_wen    = w_sel ? bus.m1_wEn          : bus.m0_wEn;
               w_addr   = w_sel ? bus.m1_address      : bus.m0_address;
               w_wdata  = w_sel ? bus.m1_write_data   : bus.m0_write_data;
               w_m0_gnt = ~w_sel;
               w_m1_gnt = w_sel;
               w_prio   = ~w_sel;
               w_state  = ACCESS;
            end
         end
         ACCESS: begin
            w_m0_valid = ~r_id;
            w_m1_valid = r_id;
            if (!r_wen) begin
               if (r_id) w_m1_rdata = bus.d_read_data;
               else      w_m0_rdata = bus.d_read_data;
            end
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   assign bus.m0_gnt       = r_m0_gnt;
   assign bus.m1_gnt       = r_m1_gnt;
   assign bus.m0_valid     = r_m0_valid;
   assign bus.m1_valid     = r_m1_valid;
   assign bus.m0_read_data = r_m0_rdata;
   assign bus.m1_read_data = r_m1_rdata;

   // RAM side is quiet outside ACCESS so a reset instantly drops any write.
   assign bus.wEn          = (r_state == ACCESS) && r_wen;
   assign bus.d_address    = (r_state == ACCESS) ? r_addr  : '0;
   assign bus.d_write_data = (r_state == ACCESS) ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed scoreboard bench for ram_port_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

   typedef struct packed {
      logic        id;
      logic        wen;
      logic [15:0] addr;
      logic [31:0] data;
   } txn_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic ram_init = 1'b1;

   int checks = 0;
   int errors = 0;

   txn_t        gq[$];
   txn_t        vq[$];
   logic [31:0] ref_mem [64];
   logic [31:0] exp_rd  [2];
   logic [31:0] mem     [64];

   ram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

   ram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // RAM model: combinational read, write on the rising edge; word i holds i.
   assign bus.d_read_data = mem[bus.d_address[7:2]];
   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      end else if (bus.wEn) begin
         mem[bus.d_address[7:2]] <= bus.d_write_data;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      txn_t t;
      if (bus.m0_gnt || bus.m1_gnt) begin
         if (gq.size() == 0) begin
            check("gnt_unexpected", {62'd0, bus.m1_gnt, bus.m0_gnt}, 64'd0);
         end else begin
            t = gq.pop_front();
            check("gnt_id", {62'd0, bus.m1_gnt, bus.m0_gnt}, t.id ? 64'd2 : 64'd1);
            check("ram_wEn", {63'd0, bus.wEn}, {63'd0, t.wen});
            check("ram_addr", {48'd0, bus.d_address}, {48'd0, t.addr});
            check("ram_wdata", {32'd0, bus.d_write_data}, {32'd0, t.data});
         end
      end else begin
         check("idle_ram", {15'd0, bus.wEn, bus.d_address, bus.d_write_data}, 64'd0);
      end
      if (bus.m0_valid || bus.m1_valid) begin
         if (vq.size() == 0) begin
            check("valid_unexpected", {62'd0, bus.m1_valid, bus.m0_valid}, 64'd0);
         end else begin
            t = vq.pop_front();
            if (!t.wen) exp_rd[t.id] = t.data;
            check("valid_id", {62'd0, bus.m1_valid, bus.m0_valid}, t.id ? 64'd2 : 64'd1);
         end
      end
      check("m0_read_data", {32'd0, bus.m0_read_data}, {32'd0, exp_rd[0]});
      check("m1_read_data", {32'd0, bus.m1_read_data}, {32'd0, exp_rd[1]});
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         monitor();
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push(input logic id, input logic wen, input logic [15:0] addr,
                       input logic [31:0] wd);
      gq.push_back('{id: id, wen: wen, addr: addr, data: wd});
      if (wen) begin
         ref_mem[addr[7:2]] = wd;
         vq.push_back('{id: id, wen: wen, addr: addr, data: wd});
      end else begin
         vq.push_back('{id: id, wen: wen, addr: addr, data: ref_mem[addr[7:2]]});
      end
   endtask

   task automatic drive(input logic id, input logic req, input logic wen,
                        input logic [15:0] addr, input logic [31:0] wd);
      if (id) begin
         bus.m1_req = req; bus.m1_wEn = wen; bus.m1_address = addr; bus.m1_write_data = wd;
      end else begin
         bus.m0_req = req; bus.m0_wEn = wen; bus.m0_address = addr; bus.m0_write_data = wd;
      end
   endtask

   task automatic issue(input logic id, input logic wen, input logic [15:0] addr,
                        input logic [31:0] wd);
      push(id, wen, addr, wd);
      drive(id, 1'b1, wen, addr, wd);
      run_cycles(1);
      drive(id, 1'b0, 1'b0, 16'd0, 32'd0);
      run_cycles(2);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0);

      // Reset state, observed while reset is still asserted.
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_gnt_valid", {60'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_valid, bus.m1_valid}, 64'd0);
      check("rst_rdata", {bus.m0_read_data, bus.m1_read_data}, 64'd0);
      check("rst_ram", {15'd0, bus.wEn, bus.d_address, bus.d_write_data}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      ram_init = 1'b0;

      // Idle: no requests, RAM port quiet, no pulses.
      run_cycles(10);

      // m1 write then read back; m0 outputs stay 0.
      issue(1'b1, 1'b1, 16'd16, 32'h0000_000A);
      issue(1'b1, 1'b0, 16'd16, 32'd0);
      check("m1_readback", {32'd0, bus.m1_read_data}, 64'h0000_000A);

      // Single m0 read of addr 4.
      issue(1'b0, 1'b0, 16'd4, 32'd0);
      check("m0_single_read", {32'd0, bus.m0_read_data}, 64'h0000_0001);

      // Tie after reset with both requests held: m0, m1, m0, m1.
      do_reset();
      push(1'b0, 1'b0, 16'd8, 32'd0);
      push(1'b1, 1'b0, 16'd12, 32'd0);
      push(1'b0, 1'b0, 16'd8, 32'd0);
      push(1'b1, 1'b0, 16'd12, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 16'd8, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 16'd12, 32'd0);
      run_cycles(7);
      drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0);
      run_cycles(3);

      // A write completes with valid but leaves read data untouched.
      issue(1'b0, 1'b0, 16'd8, 32'd0);
      issue(1'b0, 1'b1, 16'd20, 32'h0000_0055);
      check("m0_keep_rdata", {32'd0, bus.m0_read_data}, 64'h0000_0002);

      // Reset in the ACCESS cycle of an m0 write of 0xFF to addr 24.
      gq.push_back('{id: 1'b0, wen: 1'b1, addr: 16'd24, data: 32'h0000_00FF});
      drive(1'b0, 1'b1, 1'b1, 16'd24, 32'h0000_00FF);
      run_cycles(1);
      drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      @(negedge clock);
      monitor();
      #1;
      reset = 1'b1;
      #1;
      check("midwr_wEn_drop", {63'd0, bus.wEn}, 64'd0);
      check("midwr_gnt_clr", {63'd0, bus.m0_gnt}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      @(negedge clock);
      check("midwr_no_valid", {62'd0, bus.m0_valid, bus.m1_valid}, 64'd0);
      @(posedge clock);
      #1;
      run_cycles(2);

      // Priority is back to m0; addr 24 still holds its old value.
      push(1'b0, 1'b0, 16'd24, 32'd0);
      push(1'b1, 1'b0, 16'd4, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 16'd24, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 16'd4, 32'd0);
      run_cycles(3);
      drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0);
      run_cycles(3);
      check("addr24_old", {32'd0, bus.m0_read_data}, 64'h0000_0006);

      check("gnt_queue_drained", 64'(gq.size()), 64'd0);
      check("valid_queue_drained", 64'(vq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
